// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Beat counter covers MAX_BURST up to 15.
  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux_2to1.sv
// Generic 2:1 data multiplexer; sel_i=1 selects in1_i.
module mux_2to1 #(
  parameter int unsigned W = 32
) (
  input  logic         sel_i,
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  output logic [W-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the register-file write port
// between the ALU (req0) and load (req1) paths; registered write-port outputs.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned MAX_BURST   = 4,
  parameter bit          ZERO_REG_WE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              mux_sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(MAX_BURST - 1);
  localparam logic [BEAT_W-1:0] BEAT_SAT  = '1;

  arb_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              last_q, last_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              mux_sel_q, mux_sel_d;

  logic              gnt0, gnt1;
  logic              xfer;
  logic              repeat_gnt;
  logic              sel_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;

  assign sel_c  = gnt1;
  assign addr_c = sel_c ? req1_addr : req0_addr;

  mux_2to1 #(.W(DATA_W)) u_data_mux (
    .sel_i (sel_c),
    .in0_i (req0_data),
    .in1_i (req1_data),
    .out_o (data_c)
  );

  // Grant decision, arbitration state update and output-register next values.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_d     = last_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    repeat_gnt = 1'b0;
    xfer       = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mux_sel_d  = mux_sel_q;

    // Reset also masks grants so no ready is seen while rst_n is low.
    if (rst_n && !hold) begin
      case (state_q)
        ST_OWN0: if (req0_valid) begin
          if ((beat_q < BURST_LIM) || !req1_valid) gnt0 = 1'b1;
          else                                     gnt1 = 1'b1;
        end
        ST_OWN1: if (req1_valid) begin
          if ((beat_q < BURST_LIM) || !req0_valid) gnt1 = 1'b1;
          else                                     gnt0 = 1'b1;
        end
        default: ;
      endcase

      // Idle, or the owner dropped valid: plain round-robin.
      if (!gnt0 && !gnt1) begin
        if (req0_valid && req1_valid) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
      end

      xfer       = gnt0 || gnt1;
      repeat_gnt = ((state_q == ST_OWN0) && gnt0) || ((state_q == ST_OWN1) && gnt1);

      if (xfer) begin
        state_d   = gnt1 ? ST_OWN1 : ST_OWN0;
        last_d    = gnt1;
        beat_d    = !repeat_gnt          ? '0 :
                    (beat_q == BEAT_SAT) ? beat_q : beat_q + BEAT_W'(1);
        wr_en_d   = ZERO_REG_WE || (addr_c != '0);
        wr_addr_d = addr_c;
        wr_data_d = data_c;
        mux_sel_d = sel_c;
      end else begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mux_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mux_sel_q <= mux_sel_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mux_sel    = mux_sel_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: instance A (MAX_BURST=2, zero-reg writes suppressed) and
// instance B (MAX_BURST=4, zero-reg writes enabled) share one stimulus stream.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, hold;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;

  logic        rdy0_a, rdy1_a, sel_a, we_a;
  logic [4:0]  wa_a;
  logic [31:0] wd_a;
  logic        rdy0_b, rdy1_b, sel_b, we_b;
  logic [4:0]  wa_b;
  logic [31:0] wd_b;

  int n_vec = 0;
  int n_err = 0;

  bit [5:0] seq_a = 6'b001100;
  bit [5:0] seq_b = 6'b110000;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_BURST(2), .ZERO_REG_WE(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0_a),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1_a),
    .mux_sel(sel_a), .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a)
  );

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_BURST(4), .ZERO_REG_WE(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0_b),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1_b),
    .mux_sel(sel_b), .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    v0 = 1'b1; a0 = 5'd4; d0 = 32'hAAAA_0000;
    v1 = 1'b1; a1 = 5'd5; d1 = 32'hBBBB_0000;

    // Reset with both requesters valid
    #3;
    chk("rst_rdy0", 32'(rdy0_a), 32'd0);
    chk("rst_rdy1", 32'(rdy1_a), 32'd0);
    chk("rst_we",   32'(we_a),   32'd0);
    chk("rst_wa",   32'(wa_a),   32'd0);
    chk("rst_wd",   wd_a,        32'd0);
    chk("rst_sel",  32'(sel_a),  32'd0);
    step();
    chk("rst_we_edge", 32'(we_a), 32'd0);
    chk("rst_rdy0_b",  32'(rdy0_b), 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    rst_n = 1'b1;

    // Single requester
    v0 = 1'b1; a0 = 5'd3; d0 = 32'hDEAD_BEEF;
    #1;
    chk("single_rdy0", 32'(rdy0_a), 32'd1);
    chk("single_rdy1", 32'(rdy1_a), 32'd0);
    step();
    chk("single_we",  32'(we_a),  32'd1);
    chk("single_wa",  32'(wa_a),  32'd3);
    chk("single_wd",  wd_a,       32'hDEAD_BEEF);
    chk("single_sel", 32'(sel_a), 32'd0);
    v0 = 1'b0;
    #1;
    chk("idle_rdy0", 32'(rdy0_a), 32'd0);
    step();
    chk("idle_we",   32'(we_a), 32'd0);
    chk("idle_wa",   32'(wa_a), 32'd3);

    // Continuous contention
    pulse_reset();
    v0 = 1'b1; a0 = 5'd1; d0 = 32'h1111_1111;
    v1 = 1'b1; a1 = 5'd2; d1 = 32'h2222_2222;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("cont_rdy0_a[%0d]", i), 32'(rdy0_a), 32'(!seq_a[i]));
      chk($sformatf("cont_rdy1_a[%0d]", i), 32'(rdy1_a), 32'(seq_a[i]));
      chk($sformatf("cont_rdy1_b[%0d]", i), 32'(rdy1_b), 32'(seq_b[i]));
      step();
      chk($sformatf("cont_sel_a[%0d]", i), 32'(sel_a), 32'(seq_a[i]));
      chk($sformatf("cont_wd_a[%0d]", i),  wd_a, seq_a[i] ? 32'h2222_2222 : 32'h1111_1111);
      chk($sformatf("cont_sel_b[%0d]", i), 32'(sel_b), 32'(seq_b[i]));
    end

    // Hold after first req1 beat
    v0 = 1'b0; v1 = 1'b0;
    pulse_reset();
    v1 = 1'b1; a1 = 5'd2; d1 = 32'h3333_3333;
    #1;
    chk("hold_first_rdy1", 32'(rdy1_a), 32'd1);
    step();
    chk("hold_first_we", 32'(we_a), 32'd1);
    hold = 1'b1; v0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold_rdy0_a[%0d]", i), 32'(rdy0_a), 32'd0);
      chk($sformatf("hold_rdy1_a[%0d]", i), 32'(rdy1_a), 32'd0);
      chk($sformatf("hold_rdy1_b[%0d]", i), 32'(rdy1_b), 32'd0);
      step();
      chk($sformatf("hold_we_a[%0d]", i), 32'(we_a), 32'd0);
      chk($sformatf("hold_we_b[%0d]", i), 32'(we_b), 32'd0);
    end
    hold = 1'b0;
    #1;
    chk("post_hold_rdy1_a", 32'(rdy1_a), 32'd1);
    chk("post_hold_rdy0_a", 32'(rdy0_a), 32'd0);
    step();
    chk("post_hold_we_a",  32'(we_a),  32'd1);
    chk("post_hold_sel_a", 32'(sel_a), 32'd1);
    #1;
    chk("yield_rdy0_a", 32'(rdy0_a), 32'd1);
    chk("yield_rdy1_a", 32'(rdy1_a), 32'd0);
    chk("yield_rdy1_b", 32'(rdy1_b), 32'd1);
    step();
    chk("yield_sel_a", 32'(sel_a), 32'd0);
    chk("yield_wa_a",  32'(wa_a),  32'd1);

    // Writes to register 0
    v0 = 1'b0; v1 = 1'b0;
    pulse_reset();
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h0000_0055;
    #1;
    chk("zero_rdy1_a", 32'(rdy1_a), 32'd1);
    chk("zero_rdy1_b", 32'(rdy1_b), 32'd1);
    step();
    chk("zero_we_a",  32'(we_a),  32'd0);
    chk("zero_we_b",  32'(we_b),  32'd1);
    chk("zero_wd_a",  wd_a,       32'h0000_0055);
    chk("zero_sel_a", 32'(sel_a), 32'd1);
    a1 = 5'd7;
    #1;
    chk("r7_rdy1_a", 32'(rdy1_a), 32'd1);
    step();
    chk("r7_we_a", 32'(we_a), 32'd1);
    chk("r7_wa_a", 32'(wa_a), 32'd7);

    // Async reset mid-burst, then owner drop
    v1 = 1'b0; v0 = 1'b1; a0 = 5'd1; d0 = 32'h0000_0066;
    #1;
    chk("mid_rdy0_a", 32'(rdy0_a), 32'd1);
    step();
    chk("mid_we_a", 32'(we_a), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_we_a",   32'(we_a),   32'd0);
    chk("arst_we_b",   32'(we_b),   32'd0);
    chk("arst_wa_a",   32'(wa_a),   32'd0);
    chk("arst_rdy0_a", 32'(rdy0_a), 32'd0);
    v1 = 1'b1; a1 = 5'd2; d1 = 32'h0000_0077;
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_rdy0_a", 32'(rdy0_a), 32'd1);
    chk("rel_rdy1_a", 32'(rdy1_a), 32'd0);
    step();
    chk("rel_sel_a", 32'(sel_a), 32'd0);
    chk("rel_wa_a",  32'(wa_a),  32'd1);
    chk("rel_we_a",  32'(we_a),  32'd1);
    v0 = 1'b0;
    #1;
    chk("drop_rdy1_a", 32'(rdy1_a), 32'd1);
    step();
    chk("drop_sel_a", 32'(sel_a), 32'd1);
    chk("drop_wd_a",  wd_a,       32'h0000_0077);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
